count_seq_checker: RTL and testbench

Receive-side monitor for the free-running wrap-around counter stream. Samples a counter value on each valid cycle and locks onto the modulo-(WRAP+1) increment sequence. Once locked, it flags every break in the sequence, counts errors and drops lock after a run of consecutive failures. It sits at the consuming end of any link carrying a counter value, as a live integrity check alongside the formal properties.

---
 rtl/count_seq_checker.sv | 191 +++++++++++++++++++
 tb/tb_count_seq_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Receive-side integrity monitor for a modulo-(WRAP+1) counter stream.
// It locks onto the increment sequence, flags breaks, counts errors and drops lock after LOSS_LEN bad samples.
module count_seq_checker #(
   parameter int unsigned WIDTH    = 6,
   parameter int unsigned WRAP     = 15,
   parameter int unsigned LOCK_LEN = 4,
   parameter int unsigned LOSS_LEN = 3,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_count_i,
   input  logic             clr_i,
   output logic             locked_o,
   output logic             err_o,
   output logic             range_err_o,
   output logic [ERR_W-1:0] err_count_o,
   output logic [WIDTH-1:0] expected_o
);

   localparam int unsigned GoodW = $clog2(LOCK_LEN + 1);
   localparam int unsigned BadW  = $clog2(LOSS_LEN + 1);

   localparam logic [WIDTH-1:0] WrapVal    = WIDTH'(WRAP);
   localparam logic [GoodW-1:0] LockLenVal = GoodW'(LOCK_LEN);
   localparam logic [BadW-1:0]  LossLenVal = BadW'(LOSS_LEN);
   localparam logic [ERR_W-1:0] ErrMax     = '1;

   typedef enum logic [1:0] {StSearch, StVerify, StLocked, StLosing} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   ref_q, ref_d;
   logic [GoodW-1:0]   good_q, good_d;
   logic [BadW-1:0]    bad_q, bad_d;
   logic               err_q, err_d;
   logic               range_q, range_d;
   logic               locked_q, locked_d;
   logic [ERR_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   expected_q, expected_d;

   logic [WIDTH-1:0]   exp_val;
   logic               in_range;
   logic               match;
   logic [GoodW-1:0]   good_inc;
   logic [BadW-1:0]    bad_inc;

   function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] v);
      return (v == WrapVal) ? '0 : v + WIDTH'(1);
   endfunction

   // ref only ever holds in-range values, so a match implies in_count <= WRAP.
   assign exp_val  = succ(ref_q);
   assign in_range = (in_count_i <= WrapVal);
   assign match    = (in_count_i == exp_val);
   assign good_inc = good_q + GoodW'(1);
   assign bad_inc  = bad_q + BadW'(1);

   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      good_d  = good_q;
      bad_d   = bad_q;
      err_d   = 1'b0;
      range_d = 1'b0;

      if (in_valid_i) begin
         unique case (state_q)
            StSearch: begin
               if (in_range) begin
                  ref_d   = in_count_i;
                  good_d  = GoodW'(1);
                  state_d = StVerify;
               end
            end
            StVerify: begin
               if (match) begin
                  ref_d  = in_count_i;
                  good_d = good_inc;
                  if (good_inc >= LockLenVal) begin
                     state_d = StLocked;
                  end
               end else if (in_range) begin
                  ref_d  = in_count_i;
                  good_d = GoodW'(1);
               end else begin
                  state_d = StSearch;
                  ref_d   = '0;
                  good_d  = '0;
               end
            end
            StLocked: begin
               if (match) begin
                  ref_d = in_count_i;
               end else begin
                  err_d   = 1'b1;
                  range_d = ~in_range;
                  // Flywheel: advance as if the sample had been correct.
                  ref_d   = exp_val;
                  if (BadW'(1) >= LossLenVal) begin
                     state_d = StSearch;
                     ref_d   = '0;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     state_d = StLosing;
                     bad_d   = BadW'(1);
                  end
               end
            end
            StLosing: begin
               if (match) begin
                  ref_d   = in_count_i;
                  bad_d   = '0;
                  state_d = StLocked;
               end else begin
                  err_d   = 1'b1;
                  range_d = ~in_range;
                  ref_d   = exp_val;
                  if (bad_inc >= LossLenVal) begin
                     state_d = StSearch;
                     ref_d   = '0;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_inc;
                  end
               end
            end
            default: begin
               state_d = StSearch;
               ref_d   = '0;
               good_d  = '0;
               bad_d   = '0;
            end
         endcase
      end
   end

   // Clear wins over the old value but still counts an error on the same edge.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = ERR_W'(err_d);
      end else if (err_d && (cnt_q != ErrMax)) begin
         cnt_d = cnt_q + ERR_W'(1);
      end
   end

   always_comb begin
      locked_d   = (state_d == StLocked) || (state_d == StLosing);
      expected_d = (state_d == StSearch) ? '0 : succ(ref_d);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StSearch;
         ref_q      <= '0;
         good_q     <= '0;
         bad_q      <= '0;
         err_q      <= 1'b0;
         range_q    <= 1'b0;
         locked_q   <= 1'b0;
         cnt_q      <= '0;
         expected_q <= '0;
      end else begin
         state_q    <= state_d;
         ref_q      <= ref_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
         err_q      <= err_d;
         range_q    <= range_d;
         locked_q   <= locked_d;
         cnt_q      <= cnt_d;
         expected_q <= expected_d;
      end
   end

   assign locked_o    = locked_q;
   assign err_o       = err_q;
   assign range_err_o = range_q;
   assign err_count_o = cnt_q;
   assign expected_o  = expected_q;

   a_range_is_err: assert property (@(posedge clk_i) disable iff (!rst_ni)
      range_err_o |-> err_o);

   a_search_expects_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == StSearch) |-> (expected_o == '0));

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed vector table, hand-written reset/range sequences
// and a randomized run checked against an arithmetic reference model.
module tb_count_seq_checker;

   localparam int WIDTH    = 6;
   localparam int WRAP     = 15;
   localparam int LOCK_LEN = 4;
   localparam int LOSS_LEN = 3;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] in_count;
   logic             clr;
   logic             locked, err, range_err;
   logic [7:0]       err_count;
   logic [WIDTH-1:0] expected;
   logic             locked2, err2, range_err2;
   logic [1:0]       err_count2;
   logic [WIDTH-1:0] expected2;

   int checks = 0;
   int errors = 0;

   count_seq_checker #(.WIDTH(WIDTH), .WRAP(WRAP), .LOCK_LEN(LOCK_LEN), .LOSS_LEN(LOSS_LEN),
                       .ERR_W(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_count_i(in_count), .clr_i(clr),
      .locked_o(locked), .err_o(err), .range_err_o(range_err), .err_count_o(err_count),
      .expected_o(expected)
   );

   count_seq_checker #(.WIDTH(WIDTH), .WRAP(WRAP), .LOCK_LEN(LOCK_LEN), .LOSS_LEN(LOSS_LEN),
                       .ERR_W(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_count_i(in_count), .clr_i(clr),
      .locked_o(locked2), .err_o(err2), .range_err_o(range_err2), .err_count_o(err_count2),
      .expected_o(expected2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit v; int c; bit cl;
      bit lk; bit er; bit re; int cnt; int cnt2; int expd;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit v, int c, bit cl, bit lk, bit er, bit re, int cnt,
                               int cnt2, int expd);
      vec_t e;
      e.v = v; e.c = c; e.cl = cl; e.lk = lk; e.er = er; e.re = re;
      e.cnt = cnt; e.cnt2 = cnt2; e.expd = expd;
      tbl.push_back(e);
   endfunction

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic check_all(input string tag, input int lk, input int er, input int re,
                            input int cnt, input int cnt2, input int expd);
      chk({tag, ".locked"}, int'(locked), lk);
      chk({tag, ".err"}, int'(err), er);
      chk({tag, ".range_err"}, int'(range_err), re);
      chk({tag, ".err_count"}, int'(err_count), cnt);
      chk({tag, ".expected"}, int'(expected), expd);
      chk({tag, ".err_count_w2"}, int'(err_count2), cnt2);
      chk({tag, ".locked_w2"}, int'(locked2), lk);
   endtask

   task automatic drive(input bit v, input int c, input bit cl);
      in_valid = v;
      in_count = WIDTH'(c);
      clr      = cl;
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain bookkeeping of the last accepted value and run lengths.
   bit m_have, m_lock, m_err, m_rerr;
   int m_ref, m_good, m_bad, m_cnt, m_cnt2;

   function automatic int m_succ(int v);
      return (v + 1) % (WRAP + 1);
   endfunction

   function automatic void model_reset();
      m_have = 0; m_lock = 0; m_err = 0; m_rerr = 0;
      m_ref = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_cnt2 = 0;
   endfunction

   function automatic int model_expected();
      return m_have ? m_succ(m_ref) : 0;
   endfunction

   function automatic void model_step(bit v, int c, bit cl);
      int nxt;
      bit match;
      m_err = 0;
      m_rerr = 0;
      if (v) begin
         nxt   = m_succ(m_ref);
         match = (c == nxt);
         if (!m_have) begin
            if (c <= WRAP) begin
               m_have = 1; m_ref = c; m_good = 1;
            end
         end else if (!m_lock) begin
            if (match) begin
               m_ref = c; m_good++;
               if (m_good >= LOCK_LEN) m_lock = 1;
            end else if (c <= WRAP) begin
               m_ref = c; m_good = 1;
            end else begin
               m_have = 0; m_ref = 0; m_good = 0;
            end
         end else if (match) begin
            m_ref = c; m_bad = 0;
         end else begin
            m_err = 1; m_rerr = (c > WRAP); m_ref = nxt; m_bad++;
            if (m_bad >= LOSS_LEN) begin
               m_lock = 0; m_have = 0; m_ref = 0; m_bad = 0; m_good = 0;
            end
         end
      end
      if (cl) begin
         m_cnt  = m_err ? 1 : 0;
         m_cnt2 = m_err ? 1 : 0;
      end else if (m_err) begin
         if (m_cnt < 255) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
      end
   endfunction

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; in_count = '0; clr = 1'b0;

      //   v  c   cl  lk er re cnt cnt2 exp
      add(1,  0, 0,  0, 0, 0, 0, 0, 1);
      add(1,  1, 0,  0, 0, 0, 0, 0, 2);
      add(1,  2, 0,  0, 0, 0, 0, 0, 3);
      add(1,  3, 0,  1, 0, 0, 0, 0, 4);
      add(1,  4, 0,  1, 0, 0, 0, 0, 5);
      add(1,  7, 0,  1, 1, 0, 1, 1, 6);
      add(1,  6, 0,  1, 0, 0, 1, 1, 7);
      add(1,  7, 0,  1, 0, 0, 1, 1, 8);
      add(1,  0, 0,  1, 1, 0, 2, 2, 9);
      add(1,  0, 0,  1, 1, 0, 3, 3, 10);
      add(1,  0, 0,  0, 1, 0, 4, 3, 0);
      add(1,  5, 0,  0, 0, 0, 4, 3, 6);
      add(1,  6, 0,  0, 0, 0, 4, 3, 7);
      add(1,  7, 0,  0, 0, 0, 4, 3, 8);
      add(1,  8, 0,  1, 0, 0, 4, 3, 9);
      add(1, 63, 0,  1, 1, 1, 5, 3, 10);
      add(1, 10, 0,  1, 0, 0, 5, 3, 11);
      add(0,  0, 0,  1, 0, 0, 5, 3, 11);
      add(0,  0, 0,  1, 0, 0, 5, 3, 11);
      add(1, 11, 0,  1, 0, 0, 5, 3, 12);
      add(1, 40, 1,  1, 1, 1, 1, 1, 13);
      add(1, 13, 0,  1, 0, 0, 1, 1, 14);
      add(1, 14, 0,  1, 0, 0, 1, 1, 15);
      add(1, 15, 0,  1, 0, 0, 1, 1, 0);
      add(1,  0, 0,  1, 0, 0, 1, 1, 1);
      add(1,  1, 0,  1, 0, 0, 1, 1, 2);
      add(0,  0, 1,  1, 0, 0, 0, 0, 2);

      // Asynchronous reset before any clock edge.
      #2 rst_n = 1'b0;
      #1 check_all("reset", 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, tbl[i].c, tbl[i].cl);
         check_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].er, tbl[i].re, tbl[i].cnt,
                   tbl[i].cnt2, tbl[i].expd);
      end

      // Locked, expecting 2: one error, then reset mid-cycle with no clock edge.
      drive(1, 9, 0);
      check_all("pre_rst", 1, 1, 0, 1, 1, 3);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all("mid_rst", 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Out-of-range samples are ignored while searching.
      drive(1, 20, 0);
      check_all("search20", 0, 0, 0, 0, 0, 0);
      drive(1, 40, 0);
      check_all("search40", 0, 0, 0, 0, 0, 0);
      drive(1, 2, 0);
      check_all("search2", 0, 0, 0, 0, 0, 3);

      // Randomized run against the reference model.
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         bit v, cl;
         int c, r;
         v  = ($urandom_range(0, 9) != 0);
         cl = ($urandom_range(0, 63) == 0);
         r  = $urandom_range(0, 99);
         if (r < 85) c = m_have ? m_succ(m_ref) : $urandom_range(0, WRAP);
         else if (r < 93) c = $urandom_range(0, WRAP);
         else c = $urandom_range(0, 63);
         drive(v, c, cl);
         model_step(v, c, cl);
         check_all($sformatf("rnd%0d", n), m_lock, m_err, m_rerr, m_cnt, m_cnt2,
                   model_expected());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
